// File: rtl/control_unit.sv
// control_unit: Moore sequencer that steps fetch/execute T-states and decodes datapath controls from state and opcode.
module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic [8:0]  out_en,
  output logic [9:0]  in_en,
  output logic [4:0]  reg_ctl,
  output logic [2:0]  mem_ctl,
  output logic        alu_add,
  output logic        Run,
  output logic        Clear
);
  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  state_t state, next_state, fin;
  logic [4:0] op;
  logic r3, imm, ld, ldi, st, br, op_in, op_out, mfhi, mflo, halt, mem, single;
  logic pc_out, zlow_out, mdr_out, hi_out, lo_out, inport_out, c_out, ba_out;
  logic pc_in, z_in, mdr_in, mar_in, y_in, ir_in, outport_in, con_in;
  logic gra, grb, grc, r_in, r_out, inc_pc, rd, wr;
  logic unused_ir;
  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign r3     = op >= 5'd3 && op <= 5'd11;
  assign imm    = op >= 5'd12 && op <= 5'd14;
  assign ld     = op == 5'd0;
  assign ldi    = op == 5'd1;
  assign st     = op == 5'd2;
  assign br     = op == 5'd18;
  assign op_in  = op == 5'd22;
  assign op_out = op == 5'd23;
  assign mfhi   = op == 5'd24;
  assign mflo   = op == 5'd25;
  assign halt   = op == 5'd27;
  assign mem    = ld || st;
  // Anything that is not a multi-step class or halt finishes in T3, including unknown opcodes.
  assign single = !(r3 || imm || mem || ldi || br || halt);
  assign fin    = Stop ? HALT : T0;
  always_ff @(posedge Clock)
    state <= Reset ? next_state : RST;
  always_comb begin
    next_state = state;
    case (state)
      RST:     next_state = T0;
      T0:      next_state = T1;
      T1:      next_state = T2;
      T2:      next_state = T3;
      T3:      next_state = halt ? HALT : single ? fin : T4;
      T4:      next_state = T5;
      T5:      next_state = (r3 || imm || ldi) ? fin : T6;
      T6:      next_state = br ? fin : T7;
      T7:      next_state = fin;
      HALT:    next_state = HALT;
      default: next_state = RST;
    endcase
  end
  always_comb begin
    {pc_out, zlow_out, mdr_out, hi_out, lo_out, inport_out, c_out, ba_out} = 8'b0;
    {pc_in, z_in, mdr_in, mar_in, y_in, ir_in, outport_in, con_in} = 8'b0;
    {gra, grb, grc, r_in, r_out, inc_pc, rd, wr} = 8'b0;
    alu_add = 1'b0;
    case (state)
      T0: {pc_out, mar_in, inc_pc, z_in} = 4'hf;
      T1: {zlow_out, pc_in, rd, mdr_in} = 4'hf;
      T2: {mdr_out, ir_in} = 2'b11;
      T3: begin
        if (r3 || imm) {grb, r_out, y_in} = 3'b111;
        if (ldi || mem) {grb, ba_out, y_in} = 3'b111;
        if (br) {gra, r_out, con_in} = 3'b111;
        if (op_in) {inport_out, gra, r_in} = 3'b111;
        if (op_out) {gra, r_out, outport_in} = 3'b111;
        if (mfhi) {hi_out, gra, r_in} = 3'b111;
        if (mflo) {lo_out, gra, r_in} = 3'b111;
      end
      T4: begin
        if (r3) {grc, r_out, z_in} = 3'b111;
        if (imm) {c_out, z_in} = 2'b11;
        if (ldi || mem) {c_out, z_in, alu_add} = 3'b111;
        if (br) {pc_out, y_in} = 2'b11;
      end
      T5: begin
        if (r3 || imm || ldi) {zlow_out, gra, r_in} = 3'b111;
        if (mem) {zlow_out, mar_in} = 2'b11;
        if (br) {c_out, z_in, alu_add} = 3'b111;
      end
      T6: begin
        if (ld) {rd, mdr_in} = 2'b11;
        if (st) {gra, r_out, mdr_in} = 3'b111;
        if (br) {zlow_out, pc_in} = {1'b1, CON};
      end
      T7: begin
        if (ld) {mdr_out, gra, r_in} = 3'b111;
        if (st) wr = 1'b1;
      end
      default: ;
    endcase
  end
  assign out_en  = {pc_out, 1'b0, zlow_out, mdr_out, hi_out, lo_out, inport_out, c_out, ba_out};
  assign in_en   = {pc_in, z_in, mdr_in, mar_in, y_in, 2'b00, ir_in, outport_in, con_in};
  assign reg_ctl = {gra, grb, grc, r_in, r_out};
  assign mem_ctl = {inc_pc, rd, wr};
  assign Run     = state != RST && state != HALT;
  assign Clear   = state == RST;
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1 bit; the only clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit; synchronous, active-low (Reset=0 at a rising Clock edge resets the block).
REQ-003 SHALL have port IR, input, 32 bits; instruction register contents; opcode = IR[31:27]; valid from T3 onward.
REQ-004 SHALL have port CON, input, 1 bit; branch-condition flip-flop output from the datapath.
REQ-005 SHALL have port Stop, input, 1 bit; level request to halt at the next instruction boundary.
REQ-006 SHALL have port out_en, output, 9 bits; bus drivers {PCout,Zhighout,Zlowout,MDRout,HIout,LOout,InPortout,Cout,BAout}, MSB first.
REQ-007 SHALL have port in_en, output, 10 bits; register loads {PCin,Zin,MDRin,MARin,Yin,HIin,LOin,IRin,OutPortin,CONin}, MSB first.
REQ-008 SHALL have port reg_ctl, output, 5 bits; {Gra,Grb,Grc,Rin,Rout}.
REQ-009 SHALL have port mem_ctl, output, 3 bits; {IncPC,Read,Write}.
REQ-010 SHALL have port alu_add, output, 1 bit; forces the ALU to ADD regardless of opcode.
REQ-011 SHALL have port Run, output, 1 bit; high while executing, low in RST and HALT.
REQ-012 SHALL have port Clear, output, 1 bit; datapath clear, high only in RST.

Function
REQ-013 SHALL implement a Moore FSM with states RST, T0..T7, HALT, one state per Clock cycle; all outputs decode from state and IR[31:27] only.
REQ-014 SHALL assert at most one out_en bit in any cycle; every output bit not listed for a state SHALL be 0.
REQ-015 SHALL perform the fetch: T0 = PCout, MARin, IncPC, Zin; T1 = Zlowout, PCin, Read, MDRin; T2 = MDRout, IRin.
REQ-016 SHALL decode classes from the opcode: R3 = 00011..01011; IMM = 01100 (addi), 01101, 01110; ld = 00000; ldi = 00001; st = 00010; br = 10010; in = 10110; out = 10111; mfhi = 11000; mflo = 11001; nop = 11010; halt = 11011; every other opcode is treated as nop.
REQ-017 SHALL sequence R3: T3 = Grb, Rout, Yin; T4 = Grc, Rout, Zin; T5 = Zlowout, Gra, Rin.
REQ-018 SHALL sequence IMM: T3 = Grb, Rout, Yin; T4 = Cout, Zin; T5 = Zlowout, Gra, Rin.
REQ-019 SHALL sequence ldi: T3 = Grb, BAout, Yin; T4 = Cout, Zin, alu_add; T5 = Zlowout, Gra, Rin.
REQ-020 SHALL sequence ld: T3/T4 as ldi; T5 = Zlowout, MARin; T6 = Read, MDRin; T7 = MDRout, Gra, Rin.
REQ-021 SHALL sequence st: T3 to T5 as ld; T6 = Gra, Rout, MDRin (Read=0); T7 = Write.
REQ-022 SHALL sequence br: T3 = Gra, Rout, CONin; T4 = PCout, Yin; T5 = Cout, Zin, alu_add; T6 = Zlowout, and PCin only if CON=1 during T6.
REQ-023 SHALL sequence single-step ops in T3: in = InPortout, Gra, Rin; out = Gra, Rout, OutPortin; mfhi = HIout, Gra, Rin; mflo = LOout, Gra, Rin; nop = no signals.
REQ-024 SHALL, at the final T-state of an instruction, go to HALT if Stop=1 or the opcode is halt; otherwise go to T0.
REQ-025 SHALL, for halt, assert no signals in T3 and enter HALT on the next edge; HALT is left only by reset.
REQ-026 SHALL exit RST to T0 on the first edge with Reset=1.

Reset
REQ-027 SHALL enter RST on any edge with Reset=0, from any state including mid-instruction; the partial instruction is abandoned.
REQ-028 SHALL drive, in RST, all out_en, in_en, reg_ctl, mem_ctl and alu_add bits to 0, Run=0, Clear=1.
REQ-029 SHALL drive Run=1 in T0..T7 and Run=0 in HALT.

Verification
REQ-030 SHALL be tested: reset, then IR=0x611FFFFD (addi) -> T0/T1/T2 fetch signals; T3 {Grb,Rout,Yin}; T4 {Cout,Zin}; T5 {Zlowout,Gra,Rin}; T0 on cycle 7.
REQ-031 SHALL be tested: ld opcode -> 8-cycle instruction; T6 {Read,MDRin}; T7 {MDRout,Gra,Rin}; alu_add high only in T4.
REQ-032 SHALL be tested: br with CON=0, then with CON=1 -> T6 PCin=0 and PCin=1 respectively; Zlowout=1 in both.
REQ-033 SHALL be tested: Reset=0 during T5 of an st -> next cycle RST with all enables 0 and Clear=1; Write is never asserted.
REQ-034 SHALL be tested: Stop=1 during T5 of add -> HALT with Run=0; an unknown opcode 11111 -> nop, returning to T0 after T3.
REQ-035 SHALL be checked in every scenario: an assertion that no cycle has two out_en bits high.
